// File: rtl/vga_pattern_gen_pkg.sv
// Shared constants, types and helpers for the VGA test-pattern generator.
package vga_pattern_gen_pkg;

    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int BAR_COUNT = 8;
    localparam int BAR_WIDTH = H_ACTIVE / BAR_COUNT;

    localparam logic [11:0] COLOR_WHITE   = 12'hFFF;
    localparam logic [11:0] COLOR_YELLOW  = 12'hFF0;
    localparam logic [11:0] COLOR_CYAN    = 12'h0FF;
    localparam logic [11:0] COLOR_GREEN   = 12'h0F0;
    localparam logic [11:0] COLOR_MAGENTA = 12'hF0F;
    localparam logic [11:0] COLOR_RED     = 12'hF00;
    localparam logic [11:0] COLOR_BLUE    = 12'h00F;
    localparam logic [11:0] COLOR_BLACK   = 12'h000;

    typedef enum logic [1:0] {
        MODE_BARS    = 2'd0,
        MODE_CHECKER = 2'd1,
        MODE_BOX     = 2'd2,
        MODE_SOLID   = 2'd3
    } mode_e;

    typedef struct packed {
        logic [9:0] pos;
        logic       dir;
    } axis_t;

    function automatic logic [11:0] bar_color(input logic [2:0] idx);
        logic [11:0] color;
        case (idx)
            3'd0:    color = COLOR_WHITE;
            3'd1:    color = COLOR_YELLOW;
            3'd2:    color = COLOR_CYAN;
            3'd3:    color = COLOR_GREEN;
            3'd4:    color = COLOR_MAGENTA;
            3'd5:    color = COLOR_RED;
            3'd6:    color = COLOR_BLUE;
            default: color = COLOR_BLACK;
        endcase
        return color;
    endfunction

    // One frame of box motion on one axis; the 11-bit sums keep the edge tests free of wrap-around.
    function automatic axis_t axis_step(input axis_t cur, input logic [10:0] limit,
                                        input logic [10:0] step);
        axis_t       nxt;
        logic [10:0] pos11;
        nxt   = cur;
        pos11 = {1'b0, cur.pos};
        if (cur.dir) begin
            if (pos11 + step >= limit) begin
                nxt.pos = 10'(limit);
                nxt.dir = 1'b0;
            end else begin
                nxt.pos = 10'(pos11 + step);
            end
        end else begin
            if (pos11 <= step) begin
                nxt.pos = 10'd0;
                nxt.dir = 1'b1;
            end else begin
                nxt.pos = 10'(pos11 - step);
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/vga_pattern_gen_btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, stability counter, rising-edge pulse.
module vga_btn_debounce
    import vga_pattern_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    localparam int                CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]     LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Any sample agreeing with the accepted level restarts the count, so only an unbroken run is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b0;
            count <= '0;
            rise  <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (sync2 == level) begin
                count <= '0;
            end else if (count == LAST) begin
                level <= sync2;
                count <= '0;
                rise  <= sync2;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern generator: four selectable patterns behind a 2-stage pixel pipeline.
module vga_pattern_gen
    import vga_pattern_gen_pkg::*;
#(
    parameter int BOX_SIZE        = 32,
    parameter int BOX_STEP        = 2,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        mode_btn,
    output logic [11:0] rgb,
    output logic        hsync,
    output logic        vsync,
    output logic [1:0]  mode
);

    localparam logic [10:0] BOX_W  = 11'(BOX_SIZE);
    localparam logic [10:0] STEP_W = 11'(BOX_STEP);
    localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - BOX_SIZE);
    localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - BOX_SIZE);

    logic        frame_tick;
    logic        btn_rise;
    logic [1:0]  pending_mode;
    mode_e       mode_q;
    axis_t       box_x;
    axis_t       box_y;
    axis_t       box_x_next;
    axis_t       box_y_next;
    logic [2:0]  bar_idx;
    logic        in_box;
    logic [11:0] pix_color;
    logic [11:0] color_d1;
    logic        video_on_d1;
    logic        hsync_d1;
    logic        vsync_d1;

    vga_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (mode_btn),
        .rise (btn_rise)
    );

    assign frame_tick = (pixel_x == 10'd0) && (pixel_y == 10'(V_ACTIVE));

    // A press collected on the tick cycle lands in pending_mode after mode has sampled it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_mode <= 2'd0;
            mode_q       <= MODE_BARS;
        end else begin
            if (btn_rise) begin
                pending_mode <= pending_mode + 2'd1;
            end
            if (frame_tick) begin
                mode_q <= mode_e'(pending_mode);
            end
        end
    end

    assign mode = mode_q;

    always_comb begin
        box_x_next = axis_step(box_x, X_MAX, STEP_W);
        box_y_next = axis_step(box_y, Y_MAX, STEP_W);
    end

    // The box keeps moving while other patterns are shown so it never jumps when selected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            box_x <= '{pos: 10'd0, dir: 1'b1};
            box_y <= '{pos: 10'd0, dir: 1'b1};
        end else if (frame_tick) begin
            box_x <= box_x_next;
            box_y <= box_y_next;
        end
    end

    always_comb begin
        bar_idx = 3'd0;
        for (int i = 1; i < BAR_COUNT; i++) begin
            if (pixel_x >= 10'(i * BAR_WIDTH)) begin
                bar_idx = 3'(i);
            end
        end
    end

    always_comb begin
        in_box = ({1'b0, pixel_x} >= {1'b0, box_x.pos}) &&
                 ({1'b0, pixel_x} <  {1'b0, box_x.pos} + BOX_W) &&
                 ({1'b0, pixel_y} >= {1'b0, box_y.pos}) &&
                 ({1'b0, pixel_y} <  {1'b0, box_y.pos} + BOX_W);
    end

    always_comb begin
        pix_color = COLOR_BLACK;
        case (mode_q)
            MODE_BARS:    pix_color = bar_color(bar_idx);
            MODE_CHECKER: pix_color = (pixel_x[5] ^ pixel_y[5]) ? COLOR_WHITE : COLOR_BLACK;
            MODE_BOX:     pix_color = in_box ? COLOR_RED : COLOR_BLUE;
            MODE_SOLID:   pix_color = COLOR_WHITE;
            default:      pix_color = COLOR_BLACK;
        endcase
    end

    // Colour and both syncs share one pipeline so they leave on the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_d1    <= COLOR_BLACK;
            video_on_d1 <= 1'b0;
            hsync_d1    <= 1'b1;
            vsync_d1    <= 1'b1;
            rgb         <= COLOR_BLACK;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
        end else begin
            color_d1    <= pix_color;
            video_on_d1 <= video_on;
            hsync_d1    <= hsync_in;
            vsync_d1    <= vsync_in;
            rgb         <= video_on_d1 ? color_d1 : COLOR_BLACK;
            hsync       <= hsync_d1;
            vsync       <= vsync_d1;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen against a frame-level behavioural model.
module tb_vga_pattern_gen;

    localparam int DEB      = 8;
    localparam int BOX      = 32;
    localparam int STEP     = 2;
    localparam int PRESS_LEN = DEB + 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        video_on;
    logic        hsync_in;
    logic        vsync_in;
    logic        mode_btn;
    logic [11:0] rgb;
    logic        hsync;
    logic        vsync;
    logic [1:0]  mode;

    int checks = 0;
    int errors = 0;

    int m_mode, m_pending, m_bx, m_by;
    bit m_dx, m_dy;

    typedef struct {
        int x;
        int y;
        bit von;
        bit hs;
        bit vs;
    } pix_t;

    typedef struct {
        logic [11:0] rgb;
        bit          hs;
        bit          vs;
    } exp_t;

    pix_t pix_q[$];
    exp_t exp_q[$];

    vga_pattern_gen #(
        .BOX_SIZE(BOX),
        .BOX_STEP(STEP),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pixel_x (pixel_x),
        .pixel_y (pixel_y),
        .video_on(video_on),
        .hsync_in(hsync_in),
        .vsync_in(vsync_in),
        .mode_btn(mode_btn),
        .rgb     (rgb),
        .hsync   (hsync),
        .vsync   (vsync),
        .mode    (mode)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] model_rgb(input int x, input int y, input bit von);
        logic [11:0] c;
        c = 12'h000;
        if (von) begin
            case (m_mode)
                0: begin
                    case (x / 80)
                        0: c = 12'hFFF;
                        1: c = 12'hFF0;
                        2: c = 12'h0FF;
                        3: c = 12'h0F0;
                        4: c = 12'hF0F;
                        5: c = 12'hF00;
                        6: c = 12'h00F;
                        default: c = 12'h000;
                    endcase
                end
                1: c = (((x / 32) % 2) != ((y / 32) % 2)) ? 12'hFFF : 12'h000;
                2: c = (x >= m_bx && x < m_bx + BOX && y >= m_by && y < m_by + BOX) ?
                       12'hF00 : 12'h00F;
                default: c = 12'hFFF;
            endcase
        end
        return c;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pending = 0; m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
    endtask

    task automatic model_axis(inout int pos, inout bit dir, input int limit);
        if (dir) begin
            if (pos + STEP >= limit) begin pos = limit; dir = 0; end
            else pos = pos + STEP;
        end else begin
            if (pos <= STEP) begin pos = 0; dir = 1; end
            else pos = pos - STEP;
        end
    endtask

    task automatic drive_pixel(input pix_t p);
        pixel_x  = 10'(p.x);
        pixel_y  = 10'(p.y);
        video_on = p.von;
        hsync_in = p.hs;
        vsync_in = p.vs;
    endtask

    task automatic drive_idle();
        pix_t p;
        p = '{x: 700, y: 10, von: 0, hs: 1, vs: 1};
        drive_pixel(p);
    endtask

    task automatic do_frame_tick();
        @(negedge clk);
        pixel_x = 10'd0; pixel_y = 10'd480; video_on = 0; hsync_in = 1; vsync_in = 1;
        @(negedge clk);
        pixel_x = 10'd1;
        m_mode = m_pending;
        model_axis(m_bx, m_dx, 640 - BOX);
        model_axis(m_by, m_dy, 480 - BOX);
    endtask

    task automatic press_button();
        @(negedge clk);
        mode_btn = 1;
        repeat (PRESS_LEN) @(negedge clk);
        mode_btn = 0;
        repeat (PRESS_LEN) @(negedge clk);
        m_pending = (m_pending + 1) % 4;
    endtask

    task automatic add_random_pixels(input int n, input bit near_box);
        pix_t p;
        for (int i = 0; i < n; i++) begin
            p.von = ($urandom_range(0, 7) != 0);
            p.hs  = 1'($urandom_range(0, 1));
            p.vs  = 1'($urandom_range(0, 1));
            if (p.von) begin
                p.x = $urandom_range(0, 639);
                p.y = $urandom_range(0, 479);
                if (near_box && $urandom_range(0, 1) == 1) begin
                    p.x = m_bx + $urandom_range(0, BOX + 1) - 1;
                    p.y = m_by + $urandom_range(0, BOX + 1) - 1;
                    if (p.x < 0) p.x = 0;
                    if (p.x > 639) p.x = 639;
                    if (p.y < 0) p.y = 0;
                    if (p.y > 479) p.y = 479;
                end
            end else begin
                p.x = $urandom_range(640, 799);
                p.y = $urandom_range(0, 524);
            end
            pix_q.push_back(p);
        end
    endtask

    task automatic add_pixel(input int x, input int y);
        pix_t p;
        p = '{x: x, y: y, von: 1, hs: 1, vs: 0};
        pix_q.push_back(p);
    endtask

    // Streams pix_q through the DUT and compares every pixel two clocks after it was driven.
    task automatic run_pixels(input string name);
        pix_t p;
        exp_t e;
        int   n;
        n = pix_q.size();
        exp_q.delete();
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            if (exp_q.size() >= 2) begin
                e = exp_q.pop_front();
                checks++;
                if (rgb !== e.rgb || hsync !== e.hs || vsync !== e.vs) begin
                    errors++;
                    $display("[TB] FAIL %s: got rgb=%h hsync=%b vsync=%b, expected rgb=%h hsync=%b vsync=%b (mode %0d)",
                             name, rgb, hsync, vsync, e.rgb, e.hs, e.vs, m_mode);
                end
            end
            if (i < n) p = pix_q[i];
            else p = '{x: 700, y: 10, von: 0, hs: 1, vs: 1};
            drive_pixel(p);
            e.rgb = model_rgb(p.x, p.y, p.von);
            e.hs  = p.hs;
            e.vs  = p.vs;
            exp_q.push_back(e);
        end
        pix_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 0;
        mode_btn = 0;
        pixel_x = 10'd85; pixel_y = 10'd10; video_on = 1; hsync_in = 0; vsync_in = 0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (rgb !== 12'h000) begin errors++; $display("[TB] FAIL reset_rgb: got %h expected 000", rgb); end
        checks++;
        if (hsync !== 1'b1) begin errors++; $display("[TB] FAIL reset_hsync: got %b expected 1", hsync); end
        checks++;
        if (vsync !== 1'b1) begin errors++; $display("[TB] FAIL reset_vsync: got %b expected 1", vsync); end
        checks++;
        if (mode !== 2'd0) begin errors++; $display("[TB] FAIL reset_mode: got %0d expected 0", mode); end
        drive_idle();
        rst_n = 1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_bars_latency();
        pix_t p;
        drive_idle();
        repeat (3) @(negedge clk);
        p = '{x: 85, y: 10, von: 1, hs: 1, vs: 1};
        drive_pixel(p);
        @(negedge clk);
        checks++;
        if (rgb !== 12'h000) begin errors++; $display("[TB] FAIL bars_latency_early: got %h expected 000", rgb); end
        p.x = 300;
        drive_pixel(p);
        @(negedge clk);
        checks++;
        if (rgb !== 12'hFF0) begin errors++; $display("[TB] FAIL bars_x85: got %h expected FF0", rgb); end
        drive_idle();
        @(negedge clk);
        checks++;
        if (rgb !== 12'h0F0) begin errors++; $display("[TB] FAIL bars_x300: got %h expected 0F0", rgb); end
        add_random_pixels(40, 0);
        run_pixels("bars_random");
    endtask

    task automatic test_blanking();
        pix_t p;
        @(negedge clk);
        p = '{x: 10, y: 20, von: 1, hs: 1, vs: 1};
        drive_pixel(p);
        @(negedge clk);
        @(negedge clk);
        p = '{x: 700, y: 20, von: 0, hs: 0, vs: 1};
        drive_pixel(p);
        @(negedge clk);
        checks++;
        if (rgb !== 12'hFFF || hsync !== 1'b1) begin
            errors++;
            $display("[TB] FAIL blank_before: got rgb=%h hsync=%b expected FFF/1", rgb, hsync);
        end
        drive_idle();
        @(negedge clk);
        checks++;
        if (rgb !== 12'h000 || hsync !== 1'b0) begin
            errors++;
            $display("[TB] FAIL blank_x700: got rgb=%h hsync=%b expected 000/0", rgb, hsync);
        end
    endtask

    task automatic test_debounce();
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            mode_btn = 1;
            repeat ($urandom_range(1, DEB - 2)) @(negedge clk);
            mode_btn = 0;
            repeat ($urandom_range(1, DEB - 2)) @(negedge clk);
        end
        mode_btn = 1;
        repeat (PRESS_LEN) @(negedge clk);
        m_pending = (m_pending + 1) % 4;
        checks++;
        if (mode !== 2'(m_mode)) begin errors++; $display("[TB] FAIL debounce_before_tick: got %0d expected %0d", mode, m_mode); end
        do_frame_tick();
        checks++;
        if (mode !== 2'd1) begin errors++; $display("[TB] FAIL debounce_after_tick: got %0d expected 1", mode); end
        repeat (3 * DEB) @(negedge clk);
        mode_btn = 0;
        repeat (PRESS_LEN) @(negedge clk);
        do_frame_tick();
        checks++;
        if (mode !== 2'd1) begin errors++; $display("[TB] FAIL debounce_hold: got %0d expected 1", mode); end
        add_random_pixels(40, 0);
        run_pixels("checker_random");
    endtask

    task automatic test_mode_cycle();
        press_button();
        do_frame_tick();
        press_button();
        do_frame_tick();
        checks++;
        if (mode !== 2'd3) begin errors++; $display("[TB] FAIL cycle_start: got %0d expected 3", mode); end
        for (int k = 0; k < 4; k++) begin
            press_button();
            do_frame_tick();
            checks++;
            if (mode !== 2'(k)) begin errors++; $display("[TB] FAIL cycle_step%0d: got %0d expected %0d", k, mode, k); end
            add_random_pixels(30, k == 2);
            run_pixels("cycle_pixels");
        end
    endtask

    task automatic test_box_bounce();
        int  guard;
        press_button();
        press_button();
        press_button();
        do_frame_tick();
        checks++;
        if (mode !== 2'd2) begin errors++; $display("[TB] FAIL box_mode: got %0d expected 2", mode); end
        guard = 0;
        while (!(m_bx == 606 && m_dx) && guard < 800) begin
            do_frame_tick();
            guard++;
        end
        checks++;
        if (guard >= 800) begin errors++; $display("[TB] FAIL box_reach: model never reached bx=606, got %0d required 606", m_bx); end
        add_pixel(605, m_by); add_pixel(606, m_by); add_pixel(637, m_by); add_pixel(638, m_by);
        add_pixel(620, m_by + 31);
        if (m_by + 32 < 480) add_pixel(620, m_by + 32);
        if (m_by > 0) add_pixel(620, m_by - 1);
        run_pixels("box_at_606");
        do_frame_tick();
        add_pixel(607, m_by); add_pixel(608, m_by); add_pixel(639, m_by); add_pixel(606, m_by);
        run_pixels("box_at_608");
        do_frame_tick();
        add_pixel(605, m_by); add_pixel(606, m_by); add_pixel(637, m_by); add_pixel(638, m_by);
        add_random_pixels(30, 1);
        run_pixels("box_back_606");
    endtask

    task automatic test_reset_midline();
        pix_t p;
        @(negedge clk);
        p = '{x: 300, y: 100, von: 1, hs: 0, vs: 0};
        drive_pixel(p);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        model_reset();
        checks++;
        if (rgb !== 12'h000 || hsync !== 1'b1 || vsync !== 1'b1 || mode !== 2'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: got rgb=%h hsync=%b vsync=%b mode=%0d expected 000/1/1/0",
                     rgb, hsync, vsync, mode);
        end
        @(negedge clk);
        drive_idle();
        rst_n = 1;
        press_button();
        press_button();
        do_frame_tick();
        checks++;
        if (mode !== 2'd2) begin errors++; $display("[TB] FAIL reset_box_mode: got %0d expected 2", mode); end
        add_pixel(1, 2); add_pixel(2, 2); add_pixel(33, 33); add_pixel(34, 2); add_pixel(2, 34);
        run_pixels("reset_box_origin");
    endtask

    initial begin
        test_reset();
        test_bars_latency();
        test_blanking();
        test_debounce();
        test_mode_cycle();
        test_box_bounce();
        test_reset_midline();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        repeat (50000) @(posedge clk);
        errors++;
        $display("[TB] FAIL watchdog: cycle budget exhausted, got 50000 cycles required fewer");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 Parameter: BOX_SIZE, 32, bouncing-box edge length in pixels.
REQ-002 Parameter: BOX_STEP, 2, box displacement per frame per axis in pixels.
REQ-003 Parameter: DEBOUNCE_CYCLES, 250000, stable-input cycles required to accept a button level (10 ms at 25 MHz).
REQ-004 Port: clk  input  1  pixel clock, the same clock that drives the sync generator.
REQ-005 Port: rst_n  input  1  reset; one clock, asynchronous assert, active-low.
REQ-006 Port: pixel_x  input  10  current column from the sync generator, 0..799.
REQ-007 Port: pixel_y  input  10  current row from the sync generator, 0..524.
REQ-008 Port: video_on  input  1  high inside the 640x480 active area.
REQ-009 Port: hsync_in  input  1  horizontal sync from the sync generator, active-low.
REQ-010 Port: vsync_in  input  1  vertical sync from the sync generator, active-low.
REQ-011 Port: mode_btn  input  1  raw asynchronous push-button, active-high.
REQ-012 Port: rgb  output  12  4:4:4 colour, {R[3:0],G[3:0],B[3:0]}.
REQ-013 Port: hsync  output  1  hsync_in delayed to align with rgb.
REQ-014 Port: vsync  output  1  vsync_in delayed to align with rgb.
REQ-015 Port: mode  output  2  currently displayed pattern.

Function
REQ-016 rgb, hsync and vsync SHALL be registered with exactly 2 cycles latency from pixel_x/pixel_y/video_on/hsync_in/vsync_in; all three pass through the same 2-stage pipeline.
REQ-017 rgb SHALL be 12'h000 whenever the 2-cycle-delayed video_on is 0.
REQ-018 frame_tick SHALL pulse for one cycle when pixel_x==0 and pixel_y==480 at the inputs.
REQ-019 Mode 0 (colour bars): bar = pixel_x thresholds 80,160,...,560; bars 0..7 = FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
REQ-020 Mode 1 (checkerboard): rgb = FFF when pixel_x[5]^pixel_y[5] is 1, else 000.
REQ-021 Mode 2 (bouncing box): rgb = F00 when bx<=pixel_x<bx+BOX_SIZE and by<=pixel_y<by+BOX_SIZE, else 00F.
REQ-022 Mode 3 (solid): rgb = FFF.
REQ-023 Box state: bx (10 bit), by (10 bit), dir_x (1=right), dir_y (1=down); updated only on frame_tick, in every mode.
REQ-024 X update: if dir_x and bx+BOX_STEP >= 640-BOX_SIZE then bx=640-BOX_SIZE, dir_x=0; if !dir_x and bx <= BOX_STEP then bx=0, dir_x=1; else bx +/- BOX_STEP.
REQ-025 Y update: same rule as REQ-024 with limit 480-BOX_SIZE.
REQ-026 Comparisons in REQ-024/025 SHALL use 11-bit arithmetic; no wrap-around below 0 or above the limit.
REQ-027 mode_btn SHALL pass through a 2-flop synchronizer, then a debouncer that accepts a new level only after DEBOUNCE_CYCLES consecutive identical samples.
REQ-028 Each debounced rising edge SHALL increment pending_mode modulo 4 (3 -> 0); holding the button SHALL cause no further increments.
REQ-029 mode SHALL load pending_mode only on frame_tick; a press and a frame_tick in the same cycle SHALL apply the new value at the next frame_tick.

Reset
REQ-030 While rst_n=0: rgb=000, hsync=1, vsync=1, mode=0, pending_mode=0, bx=0, by=0, dir_x=1, dir_y=1, pipeline cleared, debounced level=0, debounce counter=0.
REQ-031 Reset asserted mid-frame SHALL take effect immediately; after release the outputs SHALL track the inputs again after 2 cycles.

Structure
REQ-032 The shared package SHALL hold H_ACTIVE=640, V_ACTIVE=480, the 12-bit colour constants and the mode encodings 0..3.
REQ-033 The debouncer (synchronizer, counter, rising-edge pulse) SHALL be the sub-module vga_btn_debounce; everything else lives in vga_pattern_gen.

Verification
REQ-034 Mode 0, input pixel_x=85, pixel_y=10, video_on=1 -> rgb=FF0 exactly 2 cycles later.
REQ-035 Input video_on=0 at pixel_x=700, hsync_in=0 -> 2 cycles later rgb=000 and hsync=0, with the hsync and rgb timing aligned.
REQ-036 Mode 2, box at bx=606, dir_x=1, BOX_SIZE=32, then one frame_tick -> bx=608, dir_x=0; next tick -> bx=606.
REQ-037 Button bouncing for fewer than DEBOUNCE_CYCLES, then held -> pending_mode increments once; mode changes only at the next pixel_y=480, pixel_x=0.
REQ-038 Four clean presses starting from mode 3 -> mode sequence 0, 1, 2, 3.
REQ-039 rst_n pulsed low mid-line -> rgb=000, hsync=vsync=1, mode=0, box at (0,0) asynchronously.
